// File: rtl/bp_me_dma_bank_arbiter.sv
// Merges per-bank L2 DMA channels onto one DRAM DMA channel: round-robin packet arbiter,
// writeback burst steering from the owning bank, and in-order fill return via a bank-id tag FIFO.
module bp_me_dma_bank_arbiter #(
  parameter int num_banks_p           = 2,
  parameter int daddr_width_p         = 28,
  parameter int fill_width_p          = 64,
  parameter int block_size_in_fills_p = 8,
  parameter int rd_tag_els_p          = 4,
  localparam int bid_w = (num_banks_p > 1) ? $clog2(num_banks_p) : 1,
  localparam int pkt_w = 1 + daddr_width_p,
  localparam int cnt_w = $clog2(block_size_in_fills_p),
  localparam int ptr_w = (rd_tag_els_p > 1) ? $clog2(rd_tag_els_p) : 1,
  localparam int occ_w = $clog2(rd_tag_els_p + 1)
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [num_banks_p-1:0][pkt_w-1:0]        dma_pkt_i,
  input  logic [num_banks_p-1:0]                   dma_pkt_v_i,
  output logic [num_banks_p-1:0]                   dma_pkt_ready_and_o,
  output logic [num_banks_p-1:0][fill_width_p-1:0] dma_data_o,
  output logic [num_banks_p-1:0]                   dma_data_v_o,
  input  logic [num_banks_p-1:0]                   dma_data_ready_and_i,
  input  logic [num_banks_p-1:0][fill_width_p-1:0] dma_data_i,
  input  logic [num_banks_p-1:0]                   dma_data_v_i,
  output logic [num_banks_p-1:0]                   dma_data_ready_and_o,
  output logic [pkt_w-1:0]                         mem_pkt_o,
  output logic                                     mem_pkt_v_o,
  input  logic                                     mem_pkt_ready_and_i,
  input  logic [fill_width_p-1:0]                  mem_data_i,
  input  logic                                     mem_data_v_i,
  output logic                                     mem_data_ready_and_o,
  output logic [fill_width_p-1:0]                  mem_data_o,
  output logic                                     mem_data_v_o,
  input  logic                                     mem_data_ready_and_i
);

  logic [bid_w-1:0]       rr_ptr_q, rr_ptr_d, grant, wr_bank_q, head;
  logic                   wr_busy_q;
  logic [cnt_w-1:0]       wr_cnt_q, rd_cnt_q;
  logic [bid_w-1:0]       tag_mem_q [rd_tag_els_p];
  logic [ptr_w-1:0]       tag_wr_q, tag_rd_q;
  logic [occ_w-1:0]       tag_cnt_q;
  logic                   tag_empty, tag_full, any;
  logic                   pkt_hs, pkt_wr, push, pop, wr_hs, rd_hs;
  logic [num_banks_p-1:0] elig;
  logic [bid_w:0]         g_inc;

  assign tag_empty = (tag_cnt_q == '0);
  assign tag_full  = (tag_cnt_q == occ_w'(rd_tag_els_p));
  assign head      = tag_mem_q[tag_rd_q];

  // Writes wait for the burst engine, reads wait for a free tag slot.
  always_comb begin
    elig = '0;
    for (int i = 0; i < num_banks_p; i++)
      elig[i] = dma_pkt_v_i[i] & (dma_pkt_i[i][pkt_w-1] ? ~wr_busy_q : ~tag_full);
  end

  always_comb begin
    logic [bid_w:0] idx;
    idx   = '0;
    grant = rr_ptr_q;
    any   = 1'b0;
    for (int k = 0; k < num_banks_p; k++) begin
      idx = {1'b0, rr_ptr_q} + (bid_w+1)'(k);
      if (idx >= (bid_w+1)'(num_banks_p)) idx = idx - (bid_w+1)'(num_banks_p);
      if (!any && elig[idx[bid_w-1:0]]) begin
        grant = idx[bid_w-1:0];
        any   = 1'b1;
      end
    end
  end

  assign g_inc    = {1'b0, grant} + (bid_w+1)'(1);
  assign rr_ptr_d = (g_inc >= (bid_w+1)'(num_banks_p)) ? '0 : g_inc[bid_w-1:0];

  assign mem_pkt_v_o = ~reset_i & any;
  assign mem_pkt_o   = dma_pkt_i[grant];
  assign pkt_hs      = mem_pkt_v_o & mem_pkt_ready_and_i;
  assign pkt_wr      = mem_pkt_o[pkt_w-1];

  always_comb begin
    dma_pkt_ready_and_o        = '0;
    dma_pkt_ready_and_o[grant] = pkt_hs;
  end

  assign mem_data_o   = dma_data_i[wr_bank_q];
  assign mem_data_v_o = ~reset_i & wr_busy_q & dma_data_v_i[wr_bank_q];
  assign wr_hs        = mem_data_v_o & mem_data_ready_and_i;

  always_comb begin
    dma_data_ready_and_o            = '0;
    dma_data_ready_and_o[wr_bank_q] = ~reset_i & wr_busy_q & mem_data_ready_and_i;
  end

  // Fill data is broadcast; only the bank at the tag FIFO head sees valid.
  assign dma_data_o           = {num_banks_p{mem_data_i}};
  assign mem_data_ready_and_o = ~reset_i & ~tag_empty & dma_data_ready_and_i[head];
  assign rd_hs                = mem_data_v_i & mem_data_ready_and_o;
  assign pop                  = rd_hs & (rd_cnt_q == cnt_w'(block_size_in_fills_p-1));
  assign push                 = pkt_hs & ~pkt_wr;

  always_comb begin
    dma_data_v_o       = '0;
    dma_data_v_o[head] = ~reset_i & ~tag_empty & mem_data_v_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr_q  <= '0;
      wr_busy_q <= 1'b0;
      wr_bank_q <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      tag_cnt_q <= '0;
    end else begin
      if (pkt_hs) rr_ptr_q <= rr_ptr_d;
      if (pkt_hs & pkt_wr) begin
        wr_busy_q <= 1'b1;
        wr_bank_q <= grant;
        wr_cnt_q  <= '0;
      end else if (wr_hs) begin
        wr_cnt_q <= wr_cnt_q + cnt_w'(1);
        if (wr_cnt_q == cnt_w'(block_size_in_fills_p-1)) wr_busy_q <= 1'b0;
      end
      if (rd_hs) rd_cnt_q <= rd_cnt_q + cnt_w'(1);
      if (push)
        tag_wr_q <= (tag_wr_q == ptr_w'(rd_tag_els_p-1)) ? '0 : tag_wr_q + ptr_w'(1);
      if (pop)
        tag_rd_q <= (tag_rd_q == ptr_w'(rd_tag_els_p-1)) ? '0 : tag_rd_q + ptr_w'(1);
      tag_cnt_q <= tag_cnt_q + occ_w'(push) - occ_w'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) tag_mem_q[tag_wr_q] <= grant;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) assert (!(mem_data_v_i && tag_empty));
  end
`endif

endmodule
